// File: rtl/y86_pkg.sv
// Y86-64 shared types and constants.
// Instruction codes, status codes, fetch states, length decode.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOV   = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH0,
    S_REGS,
    S_CONST,
    S_DONE,
    S_WAIT_PC,
    S_HALTED
  } fetch_state_t;

  typedef struct packed {
    logic need_regids;
    logic need_valc;
    logic valid;
  } ilen_t;

  function automatic ilen_t instr_len(input logic [3:0] icode);
    ilen_t r;
    r = '0;
    unique case (1'b1)
      (icode == I_HALT), (icode == I_NOP),
      (icode == I_RET):
        r = '{need_regids: 1'b0, need_valc: 1'b0, valid: 1'b1};
      (icode == I_CMOV), (icode == I_OPQ),
      (icode == I_PUSHQ), (icode == I_POPQ):
        r = '{need_regids: 1'b1, need_valc: 1'b0, valid: 1'b1};
      (icode == I_JXX), (icode == I_CALL):
        r = '{need_regids: 1'b0, need_valc: 1'b1, valid: 1'b1};
      (icode == I_IRMOVQ), (icode == I_RMMOVQ),
      (icode == I_MRMOVQ):
        r = '{need_regids: 1'b1, need_valc: 1'b1, valid: 1'b1};
      default:
        r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ifetch_len_decode.sv
// Combinational icode decode: register byte, constant, validity.
// Shared between the serial fetch and any later pipelined fetch.
module ifetch_len_decode
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  output logic       need_regids,
  output logic       need_valc,
  output logic       instr_valid
);

  ilen_t d;

  // Table lookup of the instruction shape
  always_comb begin
    d           = instr_len(icode);
    need_regids = d.need_regids;
    need_valc   = d.need_valc;
    instr_valid = d.valid;
  end

endmodule

// File: rtl/instr_fetch.sv
// Multi-cycle Y86-64 fetch over a byte-wide memory port.
// Assembles one instruction per pass and hands it to decode.
module instr_fetch
  import y86_pkg::*;
#(
  parameter int          IMEM_BYTES = 1024,
  parameter logic [63:0] RESET_PC   = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] pc_in,
  input  logic        pc_load,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [63:0] pc_out,
  output logic [2:0]  stat
);

  fetch_state_t state;
  logic [63:0]  pc;
  logic [3:0]   off;
  logic [2:0]   k;
  logic         nv;
  logic [63:0]  addr;
  logic         addr_err;
  logic         fetching;
  logic         xfer;
  logic         start;
  logic         d_regids;
  logic         d_valc;
  logic         d_valid;
  logic [3:0]   len;

  ifetch_len_decode u_dec (
    .icode       (mem_rdata[7:4]),
    .need_regids (d_regids),
    .need_valc   (d_valc),
    .instr_valid (d_valid)
  );

  // Byte address, range check, and request/handshake qualifiers
  always_comb begin
    addr     = pc + {60'b0, off};
    addr_err = addr >= 64'(IMEM_BYTES);
    fetching = (state == S_FETCH0) || (state == S_REGS) ||
               (state == S_CONST);
    mem_req  = fetching && !addr_err && !rst;
    mem_addr = addr;
    xfer     = mem_req && mem_ack;
    len      = 4'd1 + {3'b0, d_regids} + (d_valc ? 4'd8 : 4'd0);
    start    = pc_load &&
               ((state == S_WAIT_PC) ||
                ((state == S_DONE) && out_ready &&
                 (stat == STAT_AOK)));
    out_valid = (state == S_DONE);
    pc_out    = pc;
  end

  // Fetch sequencer and instruction field registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH0;
      pc    <= RESET_PC;
      off   <= 4'd0;
      k     <= 3'd0;
      nv    <= 1'b0;
      icode <= 4'h0;
      ifun  <= 4'h0;
      rA    <= REG_NONE;
      rB    <= REG_NONE;
      valC  <= 64'h0;
      valP  <= 64'h0;
      stat  <= 3'd0;
    end else if (start) begin
      state <= S_FETCH0;
      pc    <= pc_in;
      off   <= 4'd0;
      k     <= 3'd0;
      nv    <= 1'b0;
      icode <= 4'h0;
      ifun  <= 4'h0;
      rA    <= REG_NONE;
      rB    <= REG_NONE;
      valC  <= 64'h0;
      valP  <= 64'h0;
      stat  <= STAT_AOK;
    end else begin
      unique case (state)
        S_FETCH0: begin
          if (addr_err) begin
            stat  <= STAT_ADR;
            state <= S_DONE;
          end else if (xfer) begin
            icode <= mem_rdata[7:4];
            ifun  <= mem_rdata[3:0];
            off   <= off + 4'd1;
            nv    <= d_valc;
            valP  <= pc + {60'b0, len};
            if (!d_valid) begin
              stat  <= STAT_INS;
              state <= S_DONE;
            end else if (len == 4'd1) begin
              stat  <= (mem_rdata[7:4] == I_HALT) ?
                       STAT_HLT : STAT_AOK;
              state <= S_DONE;
            end else begin
              stat  <= STAT_AOK;
              state <= d_regids ? S_REGS : S_CONST;
            end
          end
        end
        S_REGS: begin
          if (addr_err) begin
            stat  <= STAT_ADR;
            state <= S_DONE;
          end else if (xfer) begin
            rA    <= mem_rdata[7:4];
            rB    <= mem_rdata[3:0];
            off   <= off + 4'd1;
            state <= nv ? S_CONST : S_DONE;
          end
        end
        S_CONST: begin
          if (addr_err) begin
            stat  <= STAT_ADR;
            state <= S_DONE;
          end else if (xfer) begin
            valC[{k, 3'b000} +: 8] <= mem_rdata;
            k   <= k + 3'd1;
            off <= off + 4'd1;
            if (k == 3'd7) state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready)
            state <= (stat != STAT_AOK) ? S_HALTED : S_WAIT_PC;
        end
        S_WAIT_PC: state <= S_WAIT_PC;
        S_HALTED:  state <= S_HALTED;
        default:   state <= S_HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch.
// Main DUT at 1 KiB, a second one with a 16-byte memory.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] pc_in = 64'h0;
  logic        pc_load = 1'b0;
  logic        out_ready = 1'b0;
  logic        mem_req, mem_ack, out_valid;
  logic [63:0] mem_addr, valC, valP, pc_out;
  logic [7:0]  mem_rdata;
  logic [3:0]  icode, ifun, rA, rB;
  logic [2:0]  stat;

  logic        s_req, s_ack, s_valid;
  logic [63:0] s_addr, s_valC, s_valP, s_pc;
  logic [7:0]  s_rdata;
  logic [3:0]  s_icode, s_ifun, s_rA, s_rB;
  logic [2:0]  s_stat;

  logic [7:0]  mem [0:1023];
  int          delay = 0;
  int          wcnt = 0;
  int          reads = 0;
  int          unstable = 0;
  logic        wait_q = 1'b0;
  logic [63:0] addr_q = 64'h0;
  int          s_reads = 0;
  logic [63:0] s_first = 64'h0;
  logic [63:0] s_last = 64'h0;

  int errors = 0;
  int checks = 0;
  int r0;
  int lat;

  always #5 clk = ~clk;

  instr_fetch u_dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_load(pc_load),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .out_valid(out_valid), .out_ready(out_ready),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .valC(valC), .valP(valP), .pc_out(pc_out), .stat(stat)
  );

  instr_fetch #(.IMEM_BYTES(16), .RESET_PC(64'd12)) u_small (
    .clk(clk), .rst(rst), .pc_in(64'h0), .pc_load(1'b0),
    .mem_req(s_req), .mem_addr(s_addr),
    .mem_rdata(s_rdata), .mem_ack(s_ack),
    .out_valid(s_valid), .out_ready(1'b0),
    .icode(s_icode), .ifun(s_ifun), .rA(s_rA), .rB(s_rB),
    .valC(s_valC), .valP(s_valP), .pc_out(s_pc), .stat(s_stat)
  );

  assign mem_ack   = mem_req && (wcnt >= delay);
  assign mem_rdata = mem[mem_addr[9:0]];
  assign s_ack     = s_req;
  assign s_rdata   = mem[s_addr[9:0]];

  // Memory wait-state counter, read log and address stability monitor
  always @(posedge clk) begin
    if (rst) begin
      wcnt   <= 0;
      wait_q <= 1'b0;
    end else begin
      wcnt <= (mem_req && !mem_ack) ? wcnt + 1 : 0;
      if (mem_req && mem_ack) reads <= reads + 1;
      if (wait_q && mem_req && (mem_addr !== addr_q))
        unstable <= unstable + 1;
      wait_q <= mem_req && !mem_ack;
      addr_q <= mem_addr;
      if (s_req && s_ack) begin
        if (s_reads == 0) s_first <= s_addr;
        s_last  <= s_addr;
        s_reads <= s_reads + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[0] = 8'h30; mem[1] = 8'hF3; mem[2] = 8'h0A;
    mem[12] = 8'h30; mem[13] = 8'hF2;
    mem[14] = 8'hAB; mem[15] = 8'hCD;
    mem[16] = 8'h11; mem[17] = 8'h22;
    mem[32] = 8'h73; mem[33] = 8'h40;
    mem[64] = 8'h63; mem[65] = 8'h33;
    mem[80] = 8'hC0;
    mem[96] = 8'h00;

    repeat (2) tick();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_req", 64'(mem_req), 64'd0);
    check("rst_rA", 64'(rA), 64'hF);
    check("rst_rB", 64'(rB), 64'hF);
    check("rst_valC", valC, 64'h0);
    check("rst_stat", 64'(stat), 64'd0);
    rst = 1'b0;

    // irmovq $10,%rbx at 0 with zero-wait memory
    check("irm_addr0", mem_addr, 64'h0);
    repeat (9) tick();
    check("irm_not_yet", 64'(out_valid), 64'd0);
    tick();
    check("irm_valid", 64'(out_valid), 64'd1);
    check("irm_icode", 64'(icode), 64'h3);
    check("irm_rA", 64'(rA), 64'hF);
    check("irm_rB", 64'(rB), 64'h3);
    check("irm_valC", valC, 64'd10);
    check("irm_valP", valP, 64'd10);
    check("irm_stat", 64'(stat), 64'd1);
    check("irm_reads", 64'(reads), 64'd10);

    // small memory: bytes 12..15 only, then ADR
    check("adr_reads", 64'(s_reads), 64'd4);
    check("adr_first", s_first, 64'd12);
    check("adr_last", s_last, 64'd15);
    check("adr_valid", 64'(s_valid), 64'd1);
    check("adr_stat", 64'(s_stat), 64'd3);
    check("adr_rB", 64'(s_rB), 64'h2);
    check("adr_valC", s_valC, 64'hCDAB);

    tick();
    check("hold_valid", 64'(out_valid), 64'd1);
    check("hold_req", 64'(mem_req), 64'd0);

    // handshake with pc_load -> jXX at 0x20
    out_ready = 1'b1; pc_load = 1'b1; pc_in = 64'h20;
    tick();
    out_ready = 1'b0; pc_load = 1'b0;
    check("j_addr", mem_addr, 64'h20);
    repeat (8) tick();
    check("j_not_yet", 64'(out_valid), 64'd0);
    tick();
    check("j_valid", 64'(out_valid), 64'd1);
    check("j_icode", 64'(icode), 64'h7);
    check("j_ifun", 64'(ifun), 64'h3);
    check("j_rA", 64'(rA), 64'hF);
    check("j_valC", valC, 64'h40);
    check("j_valP", valP, 64'h29);
    check("j_pc", pc_out, 64'h20);

    // same-cycle reload to 0x40, 3 wait states per byte
    delay = 3;
    out_ready = 1'b1; pc_load = 1'b1; pc_in = 64'h40;
    tick();
    out_ready = 1'b0; pc_load = 1'b0;
    check("op_req", 64'(mem_req), 64'd1);
    check("op_addr", mem_addr, 64'h40);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("op_latency", 64'(lat), 64'd8);
    check("op_icode", 64'(icode), 64'h6);
    check("op_ifun", 64'(ifun), 64'h3);
    check("op_rA", 64'(rA), 64'h3);
    check("op_rB", 64'(rB), 64'h3);
    check("op_valP", valP, 64'h42);
    check("op_stable", 64'(unstable), 64'd0);
    delay = 0;

    // accept without pc_load -> WAIT_PC
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    check("wait_req", 64'(mem_req), 64'd0);
    check("wait_valid", 64'(out_valid), 64'd0);

    // invalid icode 0xC at 0x50
    r0 = reads;
    pc_load = 1'b1; pc_in = 64'h50;
    tick();
    pc_load = 1'b0;
    tick();
    check("ins_valid", 64'(out_valid), 64'd1);
    check("ins_stat", 64'(stat), 64'd4);
    check("ins_reads", 64'(reads - r0), 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; pc_load = 1'b1; pc_in = 64'h60;
    repeat (2) tick();
    pc_load = 1'b0;
    check("halt_req", 64'(mem_req), 64'd0);
    check("halt_valid", 64'(out_valid), 64'd0);
    check("halt_pc", pc_out, 64'h50);

    // reset, refetch irmovq, then halt at 0x60
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    check("re_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1; pc_load = 1'b1; pc_in = 64'h60;
    tick();
    out_ready = 1'b0; pc_load = 1'b0;
    tick();
    check("hlt_valid", 64'(out_valid), 64'd1);
    check("hlt_stat", 64'(stat), 64'd2);
    check("hlt_icode", 64'(icode), 64'h0);
    check("hlt_valP", valP, 64'h61);
    out_ready = 1'b1; pc_load = 1'b1; pc_in = 64'h20;
    tick();
    out_ready = 1'b0;
    tick();
    pc_load = 1'b0;
    check("hlt_stay_req", 64'(mem_req), 64'd0);
    check("hlt_stay_pc", pc_out, 64'h60);

    // reset, then reset again in the middle of the fetch
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("mid_req", 64'(mem_req), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_req", 64'(mem_req), 64'd0);
    check("mid_rst_addr", mem_addr, 64'h0);
    tick();
    rst = 1'b0;
    repeat (9) tick();
    check("mid_not_yet", 64'(out_valid), 64'd0);
    tick();
    check("mid_valid", 64'(out_valid), 64'd1);
    check("mid_valC", valC, 64'd10);
    check("mid_pc", pc_out, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
